ls_unit: RTL and testbench

LS_UNIT -- requirements
Module: ls_unit

---
 rtl/ls_unit_pkg.sv | 21 ++
 rtl/ls_sram.sv | 30 +++
 rtl/ls_unit.sv | 101 ++++++++++
 tb/tb_ls_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ls_unit_pkg.sv
// Shared constants and types for the local-store unit: bus widths, reset level and default depth.
// Imported by ls_unit and ls_sram.
package ls_unit_pkg;

    localparam logic        RST_ACTIVE    = 1'b0;
    localparam int unsigned REG_BUS128    = 128;
    localparam int unsigned REG_ADDR_BUS7 = 7;
    localparam int unsigned UID_W         = 3;
    localparam int unsigned LS_QW_DEFAULT = 2048;

    // Writeback tag that travels alongside a load through the pipeline.
    typedef struct packed {
        logic [REG_ADDR_BUS7-1:0] rtaddr;
        logic [UID_W-1:0]         uid;
    } ld_tag_t;

    function automatic logic is_unaligned(input logic [3:0] lo);
        return lo != 4'd0;
    endfunction

endpackage

// File: rtl/ls_sram.sv
// Single-port 1RW local-store array: synchronous read, write-first, no reset on contents.
// One access per cycle; a write also drives the written data onto rdata.
module ls_sram
    import ls_unit_pkg::*;
#(
    parameter int unsigned LS_QW = LS_QW_DEFAULT,
    localparam int unsigned AW   = $clog2(LS_QW)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [0:REG_BUS128-1] wdata,
    output logic [0:REG_BUS128-1] rdata
);

    logic [0:REG_BUS128-1] mem [LS_QW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata     <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ls_unit.sv
// Local-store unit: quadword load/store front end with a fixed two-cycle load return,
// flush of in-flight loads, a sticky unaligned flag and a wrapping request counter.
module ls_unit
    import ls_unit_pkg::*;
#(
    parameter int unsigned LS_QW = LS_QW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ils_valid,
    input  logic                     ils_store,
    input  logic [0:31]              ils_addr,
    input  logic [0:REG_BUS128-1]    ils_rt,
    input  logic [0:REG_ADDR_BUS7-1] ils_rtaddr,
    input  logic [0:UID_W-1]         ils_uid,
    input  logic                     ils_flush,
    output logic [0:REG_ADDR_BUS7-1] ls_rtaddr_o,
    output logic                     ls_wreg_o,
    output logic [0:REG_BUS128-1]    ls_rt_o,
    output logic [0:UID_W-1]         ls_uid_o,
    output logic                     ls_unaligned_o,
    output logic [0:15]              ls_req_cnt_o
);

    localparam int unsigned AW = $clog2(LS_QW);

    logic [AW-1:0]         qw_idx;
    logic                  is_load;
    logic [0:REG_BUS128-1] sram_rdata;
    logic                  unused_addr_hi;

    // Bits above the array size are dropped so addresses wrap modulo the store size.
    assign qw_idx         = ils_addr[28-AW:27];
    assign unused_addr_hi = ^ils_addr[0:27-AW];
    assign is_load        = ils_valid & ~ils_store;

    ls_sram #(
        .LS_QW (LS_QW)
    ) u_sram (
        .clk   (clk),
        .en    (ils_valid),
        .we    (ils_store),
        .addr  (qw_idx),
        .wdata (ils_rt),
        .rdata (sram_rdata)
    );

    logic                  rd_vld_q;
    ld_tag_t               rd_tag_q;
    logic                  dat_vld_q;
    ld_tag_t               dat_tag_q;
    logic [0:REG_BUS128-1] dat_q;

    // Stage 1 holds the load while the array read completes; stage 2 holds the read data.
    // A flush kills whatever is in stage 1 and whatever is being sampled this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            rd_vld_q    <= 1'b0;
            rd_tag_q    <= '0;
            dat_vld_q   <= 1'b0;
            dat_tag_q   <= '0;
            dat_q       <= '0;
            ls_wreg_o   <= 1'b0;
            ls_rtaddr_o <= '0;
            ls_uid_o    <= '0;
            ls_rt_o     <= '0;
        end else begin
            rd_vld_q <= is_load & ~ils_flush;
            if (is_load) begin
                rd_tag_q.rtaddr <= ils_rtaddr;
                rd_tag_q.uid    <= ils_uid;
            end

            dat_vld_q <= rd_vld_q & ~ils_flush;
            if (rd_vld_q) begin
                dat_tag_q <= rd_tag_q;
                dat_q     <= sram_rdata;
            end

            ls_wreg_o <= dat_vld_q;
            if (dat_vld_q) begin
                ls_rtaddr_o <= dat_tag_q.rtaddr;
                ls_uid_o    <= dat_tag_q.uid;
                ls_rt_o     <= dat_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            ls_unaligned_o <= 1'b0;
            ls_req_cnt_o   <= '0;
        end else if (ils_valid) begin
            ls_req_cnt_o <= ls_req_cnt_o + 16'd1;
            if (is_unaligned(ils_addr[28:31])) begin
                ls_unaligned_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ls_unit.sv
// Directed self-checking bench for ls_unit: store/load round trips, forwarding, wrap-around,
// flush, unaligned flag, reset during a load and counter wrap.
module tb_ls_unit;

    logic         clk;
    logic         rst;
    logic         ils_valid;
    logic         ils_store;
    logic [0:31]  ils_addr;
    logic [0:127] ils_rt;
    logic [0:6]   ils_rtaddr;
    logic [0:2]   ils_uid;
    logic         ils_flush;
    logic [0:6]   ls_rtaddr_o;
    logic         ls_wreg_o;
    logic [0:127] ls_rt_o;
    logic [0:2]   ls_uid_o;
    logic         ls_unaligned_o;
    logic [0:15]  ls_req_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] D1 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;
    localparam logic [127:0] D3 = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
    localparam logic [127:0] D4 = 128'h1357_9BDF_2468_ACE0_1122_3344_5566_7788;

    ls_unit #(
        .LS_QW (2048)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ils_valid      (ils_valid),
        .ils_store      (ils_store),
        .ils_addr       (ils_addr),
        .ils_rt         (ils_rt),
        .ils_rtaddr     (ils_rtaddr),
        .ils_uid        (ils_uid),
        .ils_flush      (ils_flush),
        .ls_rtaddr_o    (ls_rtaddr_o),
        .ls_wreg_o      (ls_wreg_o),
        .ls_rt_o        (ls_rt_o),
        .ls_uid_o       (ls_uid_o),
        .ls_unaligned_o (ls_unaligned_o),
        .ls_req_cnt_o   (ls_req_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic st, input logic [31:0] addr,
                         input logic [127:0] rt, input logic [6:0] rtaddr,
                         input logic [2:0] uid, input logic fl);
        ils_valid  = v;
        ils_store  = st;
        ils_addr   = addr;
        ils_rt     = rt;
        ils_rtaddr = rtaddr;
        ils_uid    = uid;
        ils_flush  = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 128'h0, 7'd0, 3'd0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_wreg"}, ls_wreg_o, 0);
        check({pfx, "_rt"}, ls_rt_o, 0);
        check({pfx, "_rtaddr"}, ls_rtaddr_o, 0);
        check({pfx, "_uid"}, ls_uid_o, 0);
        check({pfx, "_unal"}, ls_unaligned_o, 0);
        check({pfx, "_cnt"}, ls_req_cnt_o, 0);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        step();
        step();
        check_reset_outputs("rst");
        rst = 1'b1;
        step();

        // Store, idle, load: result two edges after the load is sampled.
        drive(1'b1, 1'b1, 32'h0000_0100, D1, 7'd0, 3'd0, 1'b0);
        step();
        idle();
        step();
        drive(1'b1, 1'b0, 32'h0000_0100, 128'h0, 7'd5, 3'd2, 1'b0);
        step();
        idle();
        check("ld1_lat1_wreg", ls_wreg_o, 0);
        step();
        check("ld1_lat2_wreg", ls_wreg_o, 0);
        step();
        check("ld1_wreg", ls_wreg_o, 1);
        check("ld1_rt", ls_rt_o, D1);
        check("ld1_rtaddr", ls_rtaddr_o, 5);
        check("ld1_uid", ls_uid_o, 2);
        step();
        check("hold_wreg", ls_wreg_o, 0);
        check("hold_rt", ls_rt_o, D1);
        check("hold_rtaddr", ls_rtaddr_o, 5);
        check("idle_cnt", ls_req_cnt_o, 2);

        // Load the cycle right after a store to the same quadword.
        drive(1'b1, 1'b1, 32'h0000_0200, D2, 7'd0, 3'd0, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0000_0200, 128'h0, 7'd9, 3'd3, 1'b0);
        step();
        idle();
        step();
        check("fwd_early_wreg", ls_wreg_o, 0);
        step();
        check("fwd_wreg", ls_wreg_o, 1);
        check("fwd_rt", ls_rt_o, D2);
        check("fwd_uid", ls_uid_o, 3);

        // 0x8040 aliases 0x0040 with a 32 KB store.
        drive(1'b1, 1'b1, 32'h0000_0040, D3, 7'd0, 3'd0, 1'b0);
        step();
        idle();
        step();
        drive(1'b1, 1'b0, 32'h0000_8040, 128'h0, 7'd1, 3'd1, 1'b0);
        step();
        idle();
        step();
        step();
        check("wrap_wreg", ls_wreg_o, 1);
        check("wrap_rt", ls_rt_o, D3);

        // Three back-to-back loads, flush with the second: only the third returns.
        drive(1'b1, 1'b0, 32'h0000_0100, 128'h0, 7'd10, 3'd1, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0000_0200, 128'h0, 7'd11, 3'd2, 1'b1);
        step();
        drive(1'b1, 1'b0, 32'h0000_0040, 128'h0, 7'd12, 3'd6, 1'b0);
        step();
        idle();
        check("fl_n_wreg", ls_wreg_o, 0);
        step();
        check("fl_n1_wreg", ls_wreg_o, 0);
        step();
        check("fl_n2_wreg", ls_wreg_o, 1);
        check("fl_n2_rtaddr", ls_rtaddr_o, 12);
        check("fl_n2_uid", ls_uid_o, 6);
        check("fl_n2_rt", ls_rt_o, D3);

        // Flush must not cancel a store sampled on the same edge.
        drive(1'b1, 1'b1, 32'h0000_0500, D4, 7'd0, 3'd0, 1'b1);
        step();
        drive(1'b1, 1'b0, 32'h0000_0500, 128'h0, 7'd20, 3'd5, 1'b0);
        step();
        idle();
        step();
        step();
        check("fl_st_wreg", ls_wreg_o, 1);
        check("fl_st_rt", ls_rt_o, D4);
        check("flush_cnt", ls_req_cnt_o, 11);
        check("aligned_unal", ls_unaligned_o, 0);

        // Unaligned load proceeds as an aligned access and sets the sticky flag.
        drive(1'b1, 1'b0, 32'h0000_0105, 128'h0, 7'd3, 3'd4, 1'b0);
        step();
        idle();
        check("unal_set", ls_unaligned_o, 1);
        step();
        step();
        check("unal_wreg", ls_wreg_o, 1);
        check("unal_rt", ls_rt_o, D1);
        step();
        check("unal_sticky", ls_unaligned_o, 1);

        // Reset with a load in flight.
        drive(1'b1, 1'b0, 32'h0000_0200, 128'h0, 7'd30, 3'd7, 1'b0);
        step();
        idle();
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("postrst_wreg", ls_wreg_o, 0);
        end

        // Counter wrap: 65535 requests reach FFFF, two more wrap to 1.
        drive(1'b1, 1'b0, 32'h0000_0000, 128'h0, 7'd0, 3'd0, 1'b0);
        for (int i = 0; i < 65535; i++) begin
            step();
        end
        check("cnt_ffff", ls_req_cnt_o, 16'hFFFF);
        step();
        check("cnt_wrap0", ls_req_cnt_o, 0);
        step();
        idle();
        step();
        check("cnt_65537", ls_req_cnt_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
